// File: rtl/mr1_mem_arbiter.sv
// mr1_mem_arbiter: 2:1 fetch/data arbiter onto one memory port.
// Optional checks: define MR1_ARB_ASSERT_EN.
module mr1_mem_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_valid,
  output logic        instr_req_ready,
  input  logic [31:0] instr_req_addr,
  output logic        instr_rsp_valid,
  output logic [31:0] instr_rsp_data,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic        data_req_wr,
  input  logic [31:0] data_req_addr,
  input  logic [1:0]  data_req_size,
  input  logic [31:0] data_req_data,
  output logic        data_rsp_valid,
  output logic [31:0] data_rsp_data,
  output logic        mem_req_valid,
  output logic        mem_req_wr,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [1:0]  mem_req_size,
  output logic [31:0] mem_req_data,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        rsp_orphan
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] route_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             lock_vld;
  logic             lock_src;
  logic             rr_last;
  logic             orphan_q;

  logic full;
  logic empty;
  logic i_elig;
  logic d_elig;
  logic grant;
  logic req_any;
  logic accept;
  logic push;
  logic pop;
  logic head;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign i_elig = instr_req_valid && !full;
  assign d_elig = data_req_valid && (data_req_wr || !full);

  // Source select: a stalled grant is held, else round-robin.
  always_comb begin
    grant   = SRC_I;
    req_any = 1'b0;
    unique case (1'b1)
      lock_vld: begin
        grant   = lock_src;
        req_any = lock_src ? data_req_valid : instr_req_valid;
      end
      (!lock_vld && i_elig && d_elig): begin
        grant   = ~rr_last;
        req_any = 1'b1;
      end
      (!lock_vld && i_elig && !d_elig): begin
        grant   = SRC_I;
        req_any = 1'b1;
      end
      (!lock_vld && !i_elig && d_elig): begin
        grant   = SRC_D;
        req_any = 1'b1;
      end
      default: begin
        grant   = SRC_I;
        req_any = 1'b0;
      end
    endcase
  end

  assign mem_req_valid = req_any && !reset;
  assign mem_req_wr    = (grant == SRC_D) && data_req_wr;
  assign mem_req_addr  = grant ? data_req_addr : instr_req_addr;
  assign mem_req_size  = grant ? data_req_size : 2'd2;
  assign mem_req_data  = grant ? data_req_data : 32'd0;

  assign instr_req_ready =
    mem_req_valid && (grant == SRC_I) && mem_req_ready;
  assign data_req_ready =
    mem_req_valid && (grant == SRC_D) && mem_req_ready;

  assign accept = mem_req_valid && mem_req_ready;
  assign push   = accept && !mem_req_wr;
  assign pop    = mem_rsp_valid && !empty;
  assign head   = route_q[rd_ptr];

  assign instr_rsp_valid = pop && (head == SRC_I) && !reset;
  assign data_rsp_valid  = pop && (head == SRC_D) && !reset;
  assign instr_rsp_data  = mem_rsp_data;
  assign data_rsp_data   = mem_rsp_data;
  assign rsp_orphan      = orphan_q;

  // Route queue storage: remember which port issued each read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      route_q <= '0;
    end else if (push) begin
      route_q[wr_ptr] <= grant;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Hold the grant across a stalled request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_src <= SRC_I;
    end else begin
      lock_vld <= mem_req_valid && !mem_req_ready;
      lock_src <= grant;
    end
  end

  // Round-robin history; starts at data so fetch wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= SRC_D;
    end else if (accept) begin
      rr_last <= grant;
    end
  end

  // Sticky flag for a response with nothing outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      orphan_q <= 1'b0;
    end else if (mem_rsp_valid && empty) begin
      orphan_q <= 1'b1;
    end
  end

`ifdef MR1_ARB_ASSERT_EN
  logic [66:0] req_now;
  logic [66:0] req_prev;

  assign req_now = {mem_req_wr, mem_req_size,
                    mem_req_addr, mem_req_data};

  // Last cycle's request, for the stability check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_prev <= '0;
    end else begin
      req_prev <= req_now;
    end
  end

  // Protocol and internal consistency checks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_rsp_valid && empty));
      assert (!lock_vld || (req_now == req_prev));
      assert (count <= FULL_CNT);
      assert (!(instr_rsp_valid && data_rsp_valid));
    end
  end
`endif

endmodule

// File: tb/tb_mr1_mem_arbiter.sv
// tb_mr1_mem_arbiter: directed bench with a route scoreboard.
// Expected responses are queued at request time.
module tb_mr1_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        instr_req_valid;
  logic        instr_req_ready;
  logic [31:0] instr_req_addr;
  logic        instr_rsp_valid;
  logic [31:0] instr_rsp_data;
  logic        data_req_valid;
  logic        data_req_ready;
  logic        data_req_wr;
  logic [31:0] data_req_addr;
  logic [1:0]  data_req_size;
  logic [31:0] data_req_data;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_wr;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [1:0]  mem_req_size;
  logic [31:0] mem_req_data;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rsp_orphan;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  mr1_mem_arbiter #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_req_valid (instr_req_valid),
    .instr_req_ready (instr_req_ready),
    .instr_req_addr  (instr_req_addr),
    .instr_rsp_valid (instr_rsp_valid),
    .instr_rsp_data  (instr_rsp_data),
    .data_req_valid  (data_req_valid),
    .data_req_ready  (data_req_ready),
    .data_req_wr     (data_req_wr),
    .data_req_addr   (data_req_addr),
    .data_req_size   (data_req_size),
    .data_req_data   (data_req_data),
    .data_rsp_valid  (data_rsp_valid),
    .data_rsp_data   (data_rsp_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_wr      (mem_req_wr),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_size    (mem_req_size),
    .mem_req_data    (mem_req_data),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .rsp_orphan      (rsp_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    instr_req_valid = 1'b0;
    data_req_valid  = 1'b0;
    data_req_wr     = 1'b0;
    mem_rsp_valid   = 1'b0;
  endtask

  task automatic push(input logic src, input logic [31:0] d);
    exp_t e;
    e.src  = src;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic rsp_start();
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_underflow: got empty want entry");
      cur = '0;
    end else begin
      cur = sb.pop_front();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = cur.data;
  endtask

  task automatic rsp_chk();
    chk("rsp_i_vld", instr_rsp_valid, !cur.src);
    chk("rsp_d_vld", data_rsp_valid, cur.src);
    if (cur.src) chk("rsp_d_dat", data_rsp_data, cur.data);
    else chk("rsp_i_dat", instr_rsp_data, cur.data);
  endtask

  task automatic reset_pulse();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    instr_req_valid = 1'b1;
    instr_req_addr  = 32'h0;
    data_req_valid  = 1'b1;
    data_req_wr     = 1'b0;
    data_req_addr   = 32'h0;
    data_req_size   = 2'd2;
    data_req_data   = 32'h0;
    mem_req_ready   = 1'b1;
    mem_rsp_valid   = 1'b1;
    mem_rsp_data    = 32'h0;

    // reset holds everything quiet
    tick();
    tick();
    settle();
    chk("rst_i_rdy", instr_req_ready, 0);
    chk("rst_d_rdy", data_req_ready, 0);
    chk("rst_m_vld", mem_req_valid, 0);
    chk("rst_i_rsp", instr_rsp_valid, 0);
    chk("rst_d_rsp", data_rsp_valid, 0);
    chk("rst_orph", rsp_orphan, 0);
    chk("rst_cnt", dut.count, 0);
    idle();
    reset = 1'b0;
    tick();

    // single fetch
    instr_req_valid = 1'b1;
    instr_req_addr  = 32'h100;
    settle();
    chk("f_vld", mem_req_valid, 1);
    chk("f_addr", mem_req_addr, 32'h100);
    chk("f_wr", mem_req_wr, 0);
    chk("f_size", mem_req_size, 2);
    chk("f_data", mem_req_data, 0);
    chk("f_i_rdy", instr_req_ready, 1);
    chk("f_d_rdy", data_req_ready, 0);
    push(1'b0, 32'hDEADBEEF);
    tick();
    instr_req_valid = 1'b0;
    rsp_start();
    settle();
    rsp_chk();
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("f_rsp_1cyc", instr_rsp_valid, 0);
    chk("f_d_quiet", data_rsp_valid, 0);

    // alternating loads from reset, then full
    reset_pulse();
    instr_req_valid = 1'b1;
    instr_req_addr  = 32'h1000;
    data_req_valid  = 1'b1;
    data_req_wr     = 1'b0;
    data_req_addr   = 32'h2000;
    data_req_size   = 2'd2;
    for (int i = 0; i < 4; i++) begin
      logic s;
      s = i[0];
      settle();
      chk("rr_i_rdy", instr_req_ready, !s);
      chk("rr_d_rdy", data_req_ready, s);
      chk("rr_addr", mem_req_addr, s ? 32'h2000 : 32'h1000);
      push(s, 32'hC0DE0000 + 32'(i));
      tick();
    end
    settle();
    chk("full_i_rdy", instr_req_ready, 0);
    chk("full_d_rdy", data_req_ready, 0);
    chk("full_m_vld", mem_req_valid, 0);
    chk("full_cnt", dut.count, 4);
    data_req_wr   = 1'b1;
    data_req_addr = 32'h2004;
    data_req_data = 32'h55;
    settle();
    chk("full_st_rdy", data_req_ready, 1);
    chk("full_st_i", instr_req_ready, 0);
    chk("full_st_wr", mem_req_wr, 1);
    chk("full_st_adr", mem_req_addr, 32'h2004);
    tick();
    data_req_valid = 1'b0;
    data_req_wr    = 1'b0;
    rsp_start();
    settle();
    chk("nobypass", instr_req_ready, 0);
    rsp_chk();
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("after_pop", instr_req_ready, 1);
    chk("after_cnt", dut.count, 3);
    push(1'b0, 32'hC0DE0010);
    tick();
    instr_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rsp_start();
      settle();
      rsp_chk();
      tick();
    end
    mem_rsp_valid = 1'b0;
    settle();
    chk("drain_cnt", dut.count, 0);

    // store sets rr_last to data, then stalled store
    data_req_valid = 1'b1;
    data_req_wr    = 1'b1;
    data_req_addr  = 32'h1FC;
    settle();
    chk("pre_st_rdy", data_req_ready, 1);
    tick();
    data_req_addr = 32'h200;
    data_req_size = 2'd0;
    data_req_data = 32'hAB;
    instr_req_addr = 32'h300;
    for (int c = 0; c < 4; c++) begin
      instr_req_valid = (c > 0);
      mem_req_ready   = (c == 3);
      settle();
      chk("lk_vld", mem_req_valid, 1);
      chk("lk_wr", mem_req_wr, 1);
      chk("lk_addr", mem_req_addr, 32'h200);
      chk("lk_size", mem_req_size, 0);
      chk("lk_data", mem_req_data, 32'hAB);
      chk("lk_d_rdy", data_req_ready, (c == 3));
      chk("lk_i_rdy", instr_req_ready, 0);
      tick();
    end
    idle();
    settle();
    chk("st_cnt", dut.count, 0);

    // push and pop together across pointer wrap
    reset_pulse();
    mem_req_ready   = 1'b1;
    instr_req_addr  = 32'h400;
    data_req_addr   = 32'h500;
    data_req_size   = 2'd2;
    instr_req_valid = 1'b1;
    settle();
    chk("w0_rdy", instr_req_ready, 1);
    push(1'b0, 32'hA0);
    tick();
    instr_req_valid = 1'b0;
    data_req_valid  = 1'b1;
    settle();
    chk("w1_rdy", data_req_ready, 1);
    push(1'b1, 32'hA1);
    tick();
    data_req_valid  = 1'b0;
    instr_req_valid = 1'b1;
    settle();
    chk("w2_rdy", instr_req_ready, 1);
    push(1'b0, 32'hA2);
    tick();
    settle();
    chk("w_cnt3", dut.count, 3);
    chk("w_wr3", dut.wr_ptr, 3);
    for (int k = 0; k < 4; k++) begin
      logic s;
      s = ~k[0];
      instr_req_valid = !s;
      data_req_valid  = s;
      rsp_start();
      settle();
      if (s) chk("pp_d_rdy", data_req_ready, 1);
      else chk("pp_i_rdy", instr_req_ready, 1);
      rsp_chk();
      push(s, 32'hB0 + 32'(k));
      tick();
      if (k == 0) begin
        chk("pp_wr_wrap", dut.wr_ptr, 0);
        chk("pp_cnt", dut.count, 3);
      end
    end
    idle();
    settle();
    chk("pp_cnt_end", dut.count, 3);
    chk("pp_rd_wrap", dut.rd_ptr, 0);
    for (int i = 0; i < 3; i++) begin
      rsp_start();
      settle();
      rsp_chk();
      tick();
    end
    mem_rsp_valid = 1'b0;
    chk("sb_empty", sb.size(), 0);

    // orphan response
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h77;
    settle();
    chk("orph_i", instr_rsp_valid, 0);
    chk("orph_d", data_rsp_valid, 0);
    chk("orph_pre", rsp_orphan, 0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("orph_set", rsp_orphan, 1);
    chk("orph_cnt", dut.count, 0);
    tick();
    tick();
    chk("orph_stick", rsp_orphan, 1);
    reset = 1'b1;
    #1;
    chk("orph_clr", rsp_orphan, 0);
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
